// File: rtl/memory_io_system.sv
// Memory/I-O decoder on the processor bus: 128-word RAM, LED register,
// synchronised switch port and a prescaled free-running timer, all read through one registered DIN.
module memory_io_system #(
  parameter int TICK_DIV = 4
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic [8:0] ADDR,
  input  logic [8:0] DOUT,
  input  logic       Write,
  input  logic [8:0] SW,
  output logic [8:0] DIN,
  output logic [8:0] LEDR,
  output logic       Tick
);

  typedef enum logic [1:0] {SEL_RAM = 2'b00, SEL_LED = 2'b01, SEL_SW = 2'b10, SEL_TMR = 2'b11} sel_e;

  sel_e        sel;
  logic [8:0]  mem [128];
  logic [8:0]  din_q, din_d;
  logic [8:0]  led_q;
  logic [8:0]  sw1_q, sw2_q;
  logic [8:0]  cnt_q;
  logic [15:0] presc_q;
  logic        tick_q;
  logic        inc;

  assign sel = sel_e'(ADDR[8:7]);
  assign inc = (presc_q == 16'(TICK_DIV - 1));

  // RAM has no reset; Resetn gating keeps an aborted access from writing.
  always_ff @(posedge Clock) begin
    if (Resetn && Write && sel == SEL_RAM) mem[ADDR[6:0]] <= DOUT;
  end

  always_comb begin
    din_d = 9'd0;
    unique case (sel)
      SEL_RAM: din_d = mem[ADDR[6:0]];
      SEL_LED: din_d = led_q;
      SEL_SW:  din_d = sw2_q;
      SEL_TMR: din_d = cnt_q;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      din_q   <= 9'd0;
      led_q   <= 9'd0;
      sw1_q   <= 9'd0;
      sw2_q   <= 9'd0;
      cnt_q   <= 9'd0;
      presc_q <= 16'd0;
      tick_q  <= 1'b0;
    end else begin
      din_q <= din_d;
      sw1_q <= SW;
      sw2_q <= sw1_q;
      if (Write && sel == SEL_LED) led_q <= DOUT;
      // A timer write overrides a coincident increment and suppresses Tick.
      if (Write && sel == SEL_TMR) begin
        cnt_q   <= DOUT;
        presc_q <= 16'd0;
        tick_q  <= 1'b0;
      end else if (inc) begin
        cnt_q   <= cnt_q + 9'd1;
        presc_q <= 16'd0;
        tick_q  <= (cnt_q == 9'h1FF);
      end else begin
        presc_q <= presc_q + 16'd1;
        tick_q  <= 1'b0;
      end
    end
  end

  assign DIN  = din_q;
  assign LEDR = led_q;
  assign Tick = tick_q;

endmodule

// File: tb/tb_memory_io_system.sv
// Scoreboard bench for memory_io_system: expected DIN values are queued as each
// bus cycle is driven and compared after the edge that produces them.
module tb_memory_io_system;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic [8:0] ADDR, DOUT, SW;
  logic       Write;
  logic [8:0] DIN, LEDR;
  logic       Tick;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [8:0] v;
  } exp_t;
  exp_t sb[$];

  memory_io_system #(.TICK_DIV(4)) dut (
    .Clock(Clock), .Resetn(Resetn), .ADDR(ADDR), .DOUT(DOUT), .Write(Write),
    .SW(SW), .DIN(DIN), .LEDR(LEDR), .Tick(Tick)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive, optionally queue the DIN expected after this edge, then compare.
  task automatic cyc(input logic [8:0] a, input logic [8:0] d, input logic w,
                     input bit en, input logic [8:0] e, input string tag);
    exp_t x;
    ADDR = a; DOUT = d; Write = w;
    if (en) sb.push_back('{tag, e});
    @(posedge Clock); #1;
    Write = 1'b0;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk(x.tag, {7'd0, DIN}, {7'd0, x.v});
    end
  endtask

  logic [8:0] r1, r2, r3;

  initial begin
    Resetn = 1'b0; ADDR = 9'd0; DOUT = 9'd0; Write = 1'b0; SW = 9'd0;
    repeat (3) @(posedge Clock);
    #1;
    chk("rst_din", {7'd0, DIN}, 16'd0);
    chk("rst_led", {7'd0, LEDR}, 16'd0);
    chk("rst_tick", {15'd0, Tick}, 16'd0);
    Resetn = 1'b1;

    // RAM write/read and neighbour isolation
    cyc(9'h006, 9'h06A, 1'b1, 1'b0, 9'h0, "");
    cyc(9'h005, 9'h1A5, 1'b1, 1'b0, 9'h0, "");
    cyc(9'h005, 9'h000, 1'b0, 1'b1, 9'h1A5, "ram_rd5");
    cyc(9'h006, 9'h000, 1'b0, 1'b1, 9'h06A, "ram_rd6");
    cyc(9'h07F, 9'h12C, 1'b1, 1'b0, 9'h0, "");
    cyc(9'h07F, 9'h000, 1'b0, 1'b1, 9'h12C, "ram_top");

    // Read-before-write
    cyc(9'h010, 9'h0F0, 1'b1, 1'b0, 9'h0, "");
    cyc(9'h010, 9'h033, 1'b1, 1'b1, 9'h0F0, "rbw_old");
    cyc(9'h010, 9'h000, 1'b0, 1'b1, 9'h033, "rbw_new");

    // LED aliasing; same-edge LED read sees the old value
    cyc(9'h0C3, 9'h155, 1'b1, 1'b0, 9'h0, "");
    chk("led_wr", {7'd0, LEDR}, 16'h155);
    cyc(9'h0FF, 9'h0A0, 1'b1, 1'b1, 9'h155, "led_rbw");
    cyc(9'h080, 9'h000, 1'b0, 1'b1, 9'h0A0, "led_alias");
    cyc(9'h0C3, 9'h155, 1'b1, 1'b0, 9'h0, "");

    // Asynchronous reset mid-cycle, with a pending LED write that must not land
    ADDR = 9'h080; DOUT = 9'h0F7; Write = 1'b1;
    #3 Resetn = 1'b0;
    #1;
    chk("arst_led", {7'd0, LEDR}, 16'd0);
    chk("arst_din", {7'd0, DIN}, 16'd0);
    @(posedge Clock); #1;
    chk("arst_nowr", {7'd0, LEDR}, 16'd0);
    Write = 1'b0;
    Resetn = 1'b1;
    cyc(9'h080, 9'h000, 1'b0, 1'b1, 9'h000, "post_rst");

    // Switch port through the synchroniser; writes ignored
    cyc(9'h0C0, 9'h03C, 1'b1, 1'b0, 9'h0, "");
    SW = 9'h0AA;
    cyc(9'h100, 9'h000, 1'b0, 1'b0, 9'h0, "");
    cyc(9'h100, 9'h000, 1'b0, 1'b0, 9'h0, "");
    cyc(9'h100, 9'h000, 1'b0, 1'b1, 9'h0AA, "sw_sync");
    cyc(9'h17F, 9'h1FF, 1'b1, 1'b1, 9'h0AA, "sw_wr");
    cyc(9'h100, 9'h000, 1'b0, 1'b1, 9'h0AA, "sw_hold");
    chk("sw_led", {7'd0, LEDR}, 16'h03C);

    // Timer: load 0x1FE, observe 0x1FF then wrap with one Tick
    cyc(9'h180, 9'h1FE, 1'b1, 1'b0, 9'h0, "");
    chk("tmr_ld_tick", {15'd0, Tick}, 16'd0);
    for (int k = 1; k <= 10; k++) begin
      logic [8:0] e;
      e = (k <= 4) ? 9'h1FE : (k <= 8) ? 9'h1FF : 9'h000;
      cyc(9'h180, 9'h000, 1'b0, 1'b1, e, $sformatf("tmr_cnt%0d", k));
      chk($sformatf("tmr_tick%0d", k), {15'd0, Tick}, (k == 8) ? 16'd1 : 16'd0);
    end

    // Timer write coincident with a wrap-increment: write wins, no Tick
    cyc(9'h1AB, 9'h1FF, 1'b1, 1'b0, 9'h0, "");
    cyc(9'h180, 9'h000, 1'b0, 1'b0, 9'h0, "");
    cyc(9'h180, 9'h000, 1'b0, 1'b0, 9'h0, "");
    cyc(9'h180, 9'h000, 1'b0, 1'b0, 9'h0, "");
    cyc(9'h180, 9'h055, 1'b1, 1'b1, 9'h1FF, "tmr_coll_old");
    chk("tmr_coll_tick", {15'd0, Tick}, 16'd0);
    for (int k = 0; k < 4; k++) begin
      cyc(9'h180, 9'h000, 1'b0, 1'b1, 9'h055, $sformatf("tmr_coll_hold%0d", k));
      chk("tmr_coll_notick", {15'd0, Tick}, 16'd0);
    end
    cyc(9'h180, 9'h000, 1'b0, 1'b1, 9'h056, "tmr_coll_inc");

    // Processor program: mvi R1,0x0C0; mvi R2,0x123; st R2,[R1]; ld R3,[R1]
    r1 = 9'h0C0;
    r2 = 9'h123;
    cyc(r1, r2, 1'b1, 1'b0, 9'h0, "");
    cyc(r1, 9'h000, 1'b0, 1'b1, 9'h123, "prog_ld");
    r3 = DIN;
    chk("prog_led", {7'd0, LEDR}, 16'h123);
    chk("prog_r3", {7'd0, r3}, 16'h123);

    chk("sb_empty", 16'(sb.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1);
  end

endmodule

// File: doc/memory_io_system.md
# memory_io_system

Memory and I/O subsystem sitting on the processor's external bus. It consumes `ADDR`, `DOUT` and `Write` from the processor and produces the processor's `DIN`. It decodes the 9-bit address space into a 128-word synchronous RAM, an LED output register, a synchronised switch input port and a free-running timer. All read data is registered, giving the one-cycle read latency the processor's fetch/load sequence relies on.

## Interface
Parameters:
- `TICK_DIV`, default 4: Clock cycles per timer increment; legal range 1..65535.

Ports:
- `Clock` in 1: system clock; everything is updated on the rising edge.
- `Resetn` in 1: reset, asynchronous and active-low.
- `ADDR` in 9: address from the processor.
- `DOUT` in 9: write data from the processor.
- `Write` in 1: 1 means write `DOUT` to `ADDR` on this edge.
- `SW` in 9: asynchronous external switches.
- `DIN` out 9: registered read data to the processor.
- `LEDR` out 9: LED register contents.
- `Tick` out 1: one-cycle pulse on the cycle the timer wraps from 511 to 0.

## Operation
Address map, decoded by `ADDR[8:7]`:
- 00: RAM, word index `ADDR[6:0]`, read/write.
- 01: LED register. All 128 offsets alias it. Read/write.
- 10: switch port. All offsets alias it. Read-only; writes are ignored.
- 11: timer count. All offsets alias it. Read returns the count; a write loads `DOUT` into the count.

Read path:
- On every edge, `DIN` <= the source selected by the current `ADDR`. This happens regardless of `Write`.
- RAM reads are read-before-write. If the same word is written on the same edge, `DIN` gets the old word.
- LED and timer reads return the value held before the edge. A same-edge write is not visible until the next edge.

Write path:
- When `Write`=1, the selected target is updated on the edge.
- `Write` is sampled every edge. A multi-cycle `Write` performs repeated writes, which is harmless.

Switch port:
- `SW` passes through a 2-flop synchroniser.
- Reads return the second flop's value.

Timer:
- 16-bit prescaler counts 0..`TICK_DIV`-1.
- When the prescaler is at `TICK_DIV`-1, the prescaler returns to 0 and the 9-bit count increments, wrapping 511 -> 0.
- `Tick` is registered. It is 1 for exactly the one cycle after the edge on which the count went 511 -> 0.
- A timer write on the same edge as an increment: the write wins, the prescaler clears to 0 and `Tick` stays 0.

Reset (asynchronous, `Resetn`=0):
- `DIN`=0, `LEDR`=0, `Tick`=0.
- Timer count=0, prescaler=0, both synchroniser flops=0.
- RAM contents are not reset and are undefined at power-up.
- Reset asserted mid-access aborts that access: no write occurs while `Resetn`=0.
- First normal edge after release: reads and writes behave normally.

## Timing
- Read latency is 1 cycle. If `ADDR` is stable before edge k, `DIN` is valid after edge k and held until edge k+1.
- Processor fetch: `ADDR` is loaded at end of T0. On the edge ending T1, `DIN` captures the word, so it is valid throughout T2 for the `IR` load. `ld`/`mvi` data is valid in T5.
- Write latency: target updated on the edge where `Write`=1. Processor `st`: `Write`/`DOUT` are registered at end of T4, so the write occurs on the edge ending the following T0.
- Switch latency: a `SW` change appears in a read 2-3 edges later.
- The timer increments every `TICK_DIV` cycles. With `TICK_DIV`=1 it increments every cycle.
- No combinational path from any input to any output.

## Test plan
- **RAM write/read:** write 0x1A5 to address 0x005 with `Write`=1 for one cycle, then hold `ADDR`=0x005 with `Write`=0 -> `DIN`=0x1A5 after the next edge. Address 0x006 is unaffected.
- **Read-before-write:** RAM[0x010]=0x0F0. Write 0x033 there -> `DIN` shows 0x0F0 after that edge and 0x033 after the following edge.
- **LED aliasing and reset:** write 0x155 to 0x0C3 -> `LEDR`=0x155. Read 0x080 -> `DIN`=0x155. Pulse `Resetn` low mid-cycle -> `LEDR`=0, `DIN`=0 immediately.
- **Switch port:** `SW`=0x0AA, `ADDR`=0x100 -> `DIN`=0x0AA within 3 edges. Write 0x1FF to 0x100 -> `DIN` still 0x0AA, `LEDR` unchanged.
- **Timer and wrap:** with `TICK_DIV`=4, write 0x1FE to 0x180 -> the count reaches 0x1FF 4 cycles later, then 0x000 after 4 more. `Tick` is high for exactly one cycle after that wrap. A write coinciding with an increment edge loads the written value and gives no `Tick`.
- **Processor program:** run `mvi` R1,0x0C0; `mvi` R2,0x123; `st` R2,[R1]; `ld` R3,[R1] -> `LEDR`=0x123 and R3=0x123.
